// File: rtl/rand_arbiter_pkg.sv
// Shared types and defaults for the random-word arbiter: FSM states, default
// LFSR polynomial/seed, and the modulo-wrap index helper.
package rand_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_RESEED = 1'b0,
        ST_RUN    = 1'b1
    } arb_state_e;

    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h0000_0481;
    localparam logic [31:0] SEED_DEFAULT      = 32'h0000_0001;

    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rand_arbiter_if.sv
// Requester-side bus of the random-word arbiter: frame marker, requests,
// one-hot grant and the random word handed to the winner.
interface rand_arbiter_if
    import rand_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = $clog2(LFSR_POLY_DEFAULT) - 1
);
    logic            frame_start;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    rnd;
    logic            rnd_valid;

    modport master (
        output frame_start, req,
        input  gnt, rnd, rnd_valid
    );

    modport slave (
        input  frame_start, req,
        output gnt, rnd, rnd_valid
    );
endinterface

// File: rtl/rand_arbiter_lfsr.sv
// Galois LFSR: init loads SEED, en advances one step, otherwise holds.
// din=1 enables polynomial feedback.
module lfsr
    import rand_arbiter_pkg::*;
#(
    parameter logic [31:0]  LFSR = LFSR_POLY_DEFAULT,
    parameter int unsigned  W    = $clog2(LFSR) - 1,
    parameter logic [W-1:0] SEED = W'(SEED_DEFAULT)
)(
    input  logic         clk,
    input  logic         en,
    input  logic         init,
    input  logic         din,
    output logic [W-1:0] lfsr
);

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur,
                                               input logic         fb_en);
        logic [W-1:0] shifted;
        shifted = {cur[W-2:0], 1'b0};
        if (fb_en && cur[W-1]) begin
            return shifted ^ LFSR[W-1:0];
        end else begin
            return shifted;
        end
    endfunction

    // LFSR state register: reseed has priority over stepping.
    always_ff @(posedge clk) begin
        if (init) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr_step(lfsr, din);
        end else begin
            lfsr <= lfsr;
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out one LFSR word per grant; the LFSR is
// reseeded at every frame start so the per-frame sequence is reproducible.
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int unsigned  NREQ = 4,
    parameter logic [31:0]  LFSR = LFSR_POLY_DEFAULT,
    parameter int unsigned  W    = $clog2(LFSR) - 1,
    parameter logic [W-1:0] SEED = W'(SEED_DEFAULT)
)(
    input  logic          clk,
    input  logic          reset,
    rand_arbiter_if.slave bus
);

    localparam int unsigned PW = $clog2(NREQ);

    arb_state_e      state_r, state_n_s;
    logic [NREQ-1:0] gnt_r, gnt_n_s, elig_s;
    logic [W-1:0]    rnd_r, rnd_n_s, lfsr_s;
    logic            rnd_valid_r, rnd_valid_n_s;
    logic [PW-1:0]   rr_r, rr_n_s, win_s;
    logic            found_s, lfsr_en_s, lfsr_init_s;

    // Round-robin search from rr_r; last cycle's winner is masked out.
    always_comb begin
        logic [PW-1:0] idx_v;
        found_s = 1'b0;
        win_s   = '0;
        idx_v   = '0;
        elig_s  = bus.req & ~gnt_r;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_v = PW'(wrap_add(32'(rr_r), i, NREQ));
            if (!found_s && elig_s[idx_v]) begin
                found_s = 1'b1;
                win_s   = idx_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic of the RESEED/RUN controller.
    always_comb begin
        state_n_s     = state_r;
        gnt_n_s       = '0;
        rnd_valid_n_s = 1'b0;
        rnd_n_s       = rnd_r;
        rr_n_s        = rr_r;
        lfsr_en_s     = 1'b0;
        lfsr_init_s   = 1'b0;
        case (state_r)
            ST_RESEED: begin
                lfsr_init_s = ~reset;
                state_n_s   = ST_RUN;
            end
            ST_RUN: begin
                if (bus.frame_start) begin
                    rr_n_s    = '0;
                    state_n_s = ST_RESEED;
                end else if (found_s) begin
                    gnt_n_s        = '0;
                    gnt_n_s[win_s] = 1'b1;
                    rnd_valid_n_s  = 1'b1;
                    rnd_n_s        = lfsr_s;
                    rr_n_s         = PW'(wrap_add(32'(win_s), 32'd1, NREQ));
                    lfsr_en_s      = ~reset;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            default: begin
                state_n_s = ST_RESEED;
            end
        endcase
    end

    // State and registered outputs; reset discards any grant in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RESEED;
            gnt_r       <= '0;
            rnd_r       <= '0;
            rnd_valid_r <= 1'b0;
            rr_r        <= '0;
        end else begin
            state_r     <= state_n_s;
            gnt_r       <= gnt_n_s;
            rnd_r       <= rnd_n_s;
            rnd_valid_r <= rnd_valid_n_s;
            rr_r        <= rr_n_s;
        end
    end

    lfsr #(
        .LFSR (LFSR),
        .W    (W),
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .en   (lfsr_en_s),
        .init (lfsr_init_s),
        .din  (1'b1),
        .lfsr (lfsr_s)
    );

    assign bus.gnt       = gnt_r;
    assign bus.rnd       = rnd_r;
    assign bus.rnd_valid = rnd_valid_r;

endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: a behavioural model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_rand_arbiter;

    localparam int          NREQ = 4;
    localparam int          W    = 10;
    localparam logic [31:0] POLY = 32'h0000_0481;
    localparam logic [W-1:0] SEED = 10'd1;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        logic            valid;
        logic [W-1:0]    rnd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    bit           m_reseed;
    int           m_ptr;
    int           m_last;
    logic [W-1:0] m_cur;
    logic [W-1:0] m_rnd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rand_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    rand_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Next random word: multiply by x modulo the feedback polynomial.
    function automatic logic [W-1:0] mulx(input logic [W-1:0] v);
        int t;
        t = int'(v) * 2;
        if (t >= (1 << W)) t = t ^ int'(POLY);
        return t[W-1:0];
    endfunction

    task automatic drive_cycle(input bit rst, input bit fs, input logic [NREQ-1:0] rq);
        exp_t e;
        bit   found;
        int   k;
        reset           = rst;
        bus.frame_start = fs;
        bus.req         = rq;
        e.cyc   = cyc + 1;
        e.gnt   = '0;
        e.valid = 1'b0;
        if (rst) begin
            m_ptr = 0; m_last = -1; m_reseed = 1'b1; m_rnd = '0;
        end else if (m_reseed) begin
            m_cur = SEED; m_reseed = 1'b0; m_last = -1;
        end else if (fs) begin
            m_ptr = 0; m_last = -1; m_reseed = 1'b1;
        end else begin
            found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (!found && rq[k] && k != m_last) begin
                    found = 1'b1;
                    e.gnt[k] = 1'b1;
                    e.valid  = 1'b1;
                    m_rnd  = m_cur;
                    m_cur  = mulx(m_cur);
                    m_ptr  = (k + 1) % NREQ;
                    m_last = k;
                end
            end
            if (!found) m_last = -1;
        end
        e.rnd = m_rnd;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs with the prediction for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_cycle %0d: expected entry never checked, required gnt=%b", e.cyc, e.gnt);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (bus.gnt !== e.gnt || bus.rnd_valid !== e.valid || bus.rnd !== e.rnd) begin
                    n_bad++;
                    $display("FAIL outputs cyc %0d: got gnt=%b valid=%b rnd=%h, required gnt=%b valid=%b rnd=%h",
                             cyc, bus.gnt, bus.rnd_valid, bus.rnd, e.gnt, e.valid, e.rnd);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rq;
        bit rst, fs;
        reset = 1'b1; bus.frame_start = 1'b0; bus.req = '0;
        m_reseed = 1'b1; m_ptr = 0; m_last = -1; m_cur = SEED; m_rnd = '0;
        @(posedge clk); #1;

        // Reset, then a single requester holding req.
        drive_cycle(1'b1, 1'b0, 4'b0000);
        drive_cycle(1'b1, 1'b0, 4'b0001);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 4'b0001);

        // All requesters constant.
        drive_cycle(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 14; i++) drive_cycle(1'b0, 1'b0, 4'b1111);

        // Frame start during continuous requests.
        drive_cycle(1'b0, 1'b1, 4'b1111);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 4'b1111);

        // Move pointer to 3, then wrap with a single-cycle pulse on index 3.
        drive_cycle(1'b0, 1'b1, 4'b0000);
        drive_cycle(1'b0, 1'b0, 4'b0000);
        drive_cycle(1'b0, 1'b0, 4'b0100);
        drive_cycle(1'b0, 1'b0, 4'b0000);
        drive_cycle(1'b0, 1'b0, 4'b1000);
        drive_cycle(1'b0, 1'b0, 4'b0000);
        drive_cycle(1'b0, 1'b0, 4'b1001);
        drive_cycle(1'b0, 1'b0, 4'b0000);

        // Reset together with frame start and full requests.
        drive_cycle(1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 4'b1111);

        // Long idle gap between two single grants.
        drive_cycle(1'b0, 1'b0, 4'b0000);
        drive_cycle(1'b0, 1'b0, 4'b0010);
        for (int i = 0; i < 100; i++) drive_cycle(1'b0, 1'b0, 4'b0000);
        drive_cycle(1'b0, 1'b0, 4'b0010);
        drive_cycle(1'b0, 1'b0, 4'b0000);

        // Randomized traffic with occasional frame starts and resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            fs  = ($urandom_range(19) == 0);
            rq  = NREQ'($urandom);
            drive_cycle(rst, fs, rq);
        end

        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
